exchange_order_tx: RTL

Exchange-facing order transmitter: the outbound counterpart of the downstream exchange receive path. Buffers risk-approved CPU orders (client id, amount) in a small FIFO and serialises each into a 5-byte frame on a byte-wide valid/ready link towards the exchange. Keeps sent and dropped counters for the risk monitor.

---
 rtl/exchange_order_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/exchange_order_tx.sv
// exchange_order_tx
// Buffers risk-approved orders {client id, amount} in a small FIFO and
// serialises each one as a 5-byte frame on a byte-wide valid/ready link:
//   SOF_BYTE, {3'b0,id}, amount[15:8], amount[7:0], XOR of the first four.
//
// Ports
//   clk              rising-edge clock
//   HRESETn          asynchronous active-low reset
//   order_go         one-cycle strobe per incoming order
//   order_client_id  client index (5 bits)
//   order_amount     order amount (16 bits); zero amounts are discarded
//   order_accept     FIFO not full; an order arriving while low is dropped
//   tx_data          frame byte
//   tx_valid         tx_data valid
//   tx_ready         link accepts the byte when tx_valid && tx_ready
//   busy             transmitter not idle or FIFO non-empty
//   fifo_level       FIFO occupancy, excluding the frame in flight
//   frames_sent      completed frames (wrapping)
//   orders_dropped   orders lost to a full FIFO (wrapping)
module exchange_order_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          HRESETn,
  input  logic                          order_go,
  input  logic [4:0]                    order_client_id,
  input  logic [15:0]                   order_amount,
  output logic                          order_accept,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frames_sent,
  output logic [15:0]                   orders_dropped
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_ID, S_AMT_HI, S_AMT_LO, S_CSUM, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [20:0]       mem_q [FIFO_DEPTH];
  logic [4:0]        hold_id_q, hold_id_d;
  logic [15:0]       hold_amt_q, hold_amt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [15:0]       frames_sent_q, frames_sent_d;
  logic [15:0]       orders_dropped_q, orders_dropped_d;

  logic              full, empty, push, drop, pop, byte_done;
  logic [20:0]       head;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Space is judged on registered state only, so a same-cycle pop never
  // makes room for a same-cycle push.
  assign order_accept = !full;
  assign push = order_go && (order_amount != '0) && !full;
  assign drop = order_go && (order_amount != '0) && full;
  assign pop  = (state_q == S_IDLE) && !empty;
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign fifo_level     = wr_ptr_q - rd_ptr_q;
  assign frames_sent    = frames_sent_q;
  assign orders_dropped = orders_dropped_q;
  assign busy           = (state_q != S_IDLE) || !empty;

  // Output bytes come straight from the holding register, so they stay
  // stable for as long as the link stalls.
  always_comb begin
    tx_valid = 1'b1;
    tx_data  = '0;
    case (state_q)
      S_SOF:    tx_data = SOF_BYTE;
      S_ID:     tx_data = {3'b000, hold_id_q};
      S_AMT_HI: tx_data = hold_amt_q[15:8];
      S_AMT_LO: tx_data = hold_amt_q[7:0];
      S_CSUM:   tx_data = SOF_BYTE ^ {3'b000, hold_id_q} ^
                          hold_amt_q[15:8] ^ hold_amt_q[7:0];
      default:  tx_valid = 1'b0;
    endcase
  end

  assign byte_done = tx_valid && tx_ready;

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    hold_id_d        = hold_id_q;
    hold_amt_d       = hold_amt_q;
    gap_cnt_d        = gap_cnt_q;
    frames_sent_d    = frames_sent_q;
    orders_dropped_d = orders_dropped_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (drop) orders_dropped_d = orders_dropped_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {hold_id_d, hold_amt_d} = head;
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = S_SOF;
        end
      end
      S_SOF:    if (byte_done) state_d = S_ID;
      S_ID:     if (byte_done) state_d = S_AMT_HI;
      S_AMT_HI: if (byte_done) state_d = S_AMT_LO;
      S_AMT_LO: if (byte_done) state_d = S_CSUM;
      S_CSUM: begin
        if (byte_done) begin
          frames_sent_d = frames_sent_q + 16'd1;
          if (GAP_CYCLES > 0) begin
            // Counter runs GAP_CYCLES-1 .. 0, one GAP cycle per value.
            gap_cnt_d = 8'(GAP_CYCLES - 1);
            state_d   = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q          <= S_IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      hold_id_q        <= '0;
      hold_amt_q       <= '0;
      gap_cnt_q        <= '0;
      frames_sent_q    <= '0;
      orders_dropped_q <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      hold_id_q        <= hold_id_d;
      hold_amt_q       <= hold_amt_d;
      gap_cnt_q        <= gap_cnt_d;
      frames_sent_q    <= frames_sent_d;
      orders_dropped_q <= orders_dropped_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {order_client_id, order_amount};
  end

endmodule
